alu_wb_stage: RTL
=================

// Module: alu_wb_stage
// PURPOSE
//  Write-back stage directly downstream of the 4-bit ALU. Captures R/zero/carry/sign from the ALU
//  into a small FIFO, then drains one entry per cycle into a 4x4-bit register file and a Z/C/S flag
//  register. Two combinational read ports feed the ALU's A/B operands, closing the datapath loop.
// PARAMETERS
//  WIDTH  4  data width of R, registers and read ports
//  NREGS  4  register-file entries; address width is clog2(NREGS)
//  DEPTH  2  pending-write FIFO depth; must be a power of two, 2..8
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      ALU result presented this cycle
//  in_ready   out  1      stage can accept; registered; equals !full
//  r_in       in   WIDTH  ALU result R
//  zero_in    in   1      ALU zero flag
//  carry_in   in   1      ALU carry; may be X, see BEHAVIOUR
//  sign_in    in   1      ALU sign; may be X, see BEHAVIOUR
//  l_in       in   1      ALU mode of the result: 0 = arithmetic, 1 = logic
//  wr_addr    in   2      destination register
//  we         in   1      write R into regfile[wr_addr]
//  flag_we    in   1      update the flag register
//  drain_en   in   1      permit FIFO head to retire this cycle; 0 = stall
//  rd_a_addr  in   2      read port A address
//  rd_b_addr  in   2      read port B address
//  rd_a       out  WIDTH  read data A; combinational
//  rd_b       out  WIDTH  read data B; combinational
//  flag_z     out  1      registered zero flag
//  flag_c     out  1      registered carry flag
//  flag_s     out  1      registered sign flag
//  count      out  clog2(DEPTH)+1  entries pending in the FIFO
// BEHAVIOUR
//  - Reset values: all regfile entries 0; flags 0; FIFO empty (count=0); in_ready=1.
//  - Push: when in_valid && in_ready, capture {r_in,z,c,s,l,wr_addr,we,flag_we} at the tail.
//    in_valid with in_ready=0 is ignored; upstream must hold the result.
//  - Pop: when drain_en && !empty, the head retires at this edge. Latency from accepted push to
//    visible regfile/flag update is 1 cycle if the FIFO was empty, plus 1 cycle per stalled entry.
//  - Retire: if we, regfile[wr_addr] <= r. If flag_we:
//      l=0: Z <= z; S <= s; C <= (carry===1'b1) ? 1 : 0. An X carry is stored as 0.
//      l=1: Z <= z; C and S hold, because the ALU drives them as X in logic mode.
//    An entry with we=0 and flag_we=0 still occupies a slot and retires as a no-op.
//  - Sanitise on push: stored carry = (carry_in===1'b1); stored sign = (sign_in===1'b1) when l=0.
//    No X ever enters architectural state.
//  - Simultaneous push and pop: allowed when not full; count unchanged; order preserved.
//    When full, in_ready=0, so a pop frees the slot and in_ready rises next cycle (registered).
//  - Empty with drain_en=1: no effect. Pointers wrap modulo DEPTH.
//  - Reset mid-operation: pending entries are discarded and never retire; the regfile clears.
//  - Reads: rd_x = regfile[rd_x_addr], subject to CONFIGURATION.
// CONFIGURATION
//  ALU_WB_BYPASS_EN defined:
//    - A read returns the youngest pending FIFO entry with we=1 and a matching address;
//      otherwise it returns the regfile.
//    - An entry retiring this cycle still bypasses.
//    - The current-cycle push (r_in) is never bypassed.
//  ALU_WB_BYPASS_EN undefined:
//    - Reads see the regfile only.
//    - Software or the control unit must drain, i.e. wait until count==0, before reading.
// STRUCTURE
//  Shared package alu_wb_pkg:
//    - WIDTH/NREGS/DEPTH defaults.
//    - wb_entry_t struct {r, z, c, s, l, addr, we, flag_we}.
//    - Flag index constants FLAG_Z=0, FLAG_C=1, FLAG_S=2.
//  One sub-module, wb_fifo: a parameterised circular buffer of wb_entry_t.
//    - Exposes head, full, empty and count.
//    - Exposes the entry array so the parent can implement bypass.
//  Regfile, flag register and read muxes live in alu_wb_stage.
// TESTING
//  1 Push R=4'hA, we=1, addr=2, l=0, c=1, s=1, z=0 with drain_en=1:
//    next cycle regfile[2]=A, C=1, S=1, Z=0.
//  2 l=1, flag_we=1, z=1, carry/sign driven X, prior C=1, S=1:
//    after retire Z=1, C=1, S=1, and no X appears on any flag.
//  3 drain_en=0, push 2 entries: count=2 and in_ready=0; a 3rd in_valid is dropped.
//    Then drain_en=1: both retire in order, in_ready=1 one cycle after the first pop.
//  4 Full FIFO, in_valid=1 and drain_en=1 in the same cycle: count goes 2->1 and no push.
//    Next cycle push+pop together keeps count=1.
//  5 Bypass build: two pending writes to addr 1 (3 then 5), rd_a_addr=1 -> rd_a=5.
//    No-bypass build -> old regfile value until count==0.
//  6 Reset asserted with count=2 and drain_en=1: next cycle count=0, all registers 0,
//    flags 0, and no pending write lands after reset.

Source files
------------

// File: rtl/alu_wb_pkg.sv
// Shared types and defaults for the ALU write-back stage.
// Bypass reads are enabled by defining ALU_WB_BYPASS_EN.
package alu_wb_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_NREGS = 4;
    localparam int unsigned DEF_DEPTH = 2;
    localparam int unsigned DEF_AW    = $clog2(DEF_NREGS);

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_S = 2;

    typedef enum logic {
        MODE_ARITH = 1'b0,
        MODE_LOGIC = 1'b1
    } alu_mode_e;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] r;
        logic                 z;
        logic                 c;
        logic                 s;
        alu_mode_e            l;
        logic [DEF_AW-1:0]    addr;
        logic                 we;
        logic                 flag_we;
    } wb_entry_t;

    // X or Z from the ALU collapses to 0 so nothing unknown reaches state.
    function automatic logic known_one(input logic v);
        return (v === 1'b1);
    endfunction

endpackage

// File: rtl/alu_wb_stage_if.sv
// ALU result handshake bus between the ALU (master) and the write-back stage (slave).
interface alu_wb_stage_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned AW    = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] r_in;
    logic             zero_in;
    logic             carry_in;
    logic             sign_in;
    logic             l_in;
    logic [AW-1:0]    wr_addr;
    logic             we;
    logic             flag_we;

    modport master (
        output in_valid, r_in, zero_in, carry_in, sign_in, l_in, wr_addr, we, flag_we,
        input  in_ready
    );

    modport slave (
        input  in_valid, r_in, zero_in, carry_in, sign_in, l_in, wr_addr, we, flag_we,
        output in_ready
    );
endinterface

// File: rtl/alu_wb_stage_fifo.sv
// wb_fifo: circular buffer of pending write-back entries.
// With ALU_WB_BYPASS_EN defined the storage array and head pointer are exported for bypass.
module wb_fifo
    import alu_wb_pkg::*;
#(
    parameter  int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  wb_entry_t     push_data,
    input  logic          pop,
    output wb_entry_t     head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
`ifdef ALU_WB_BYPASS_EN
    ,
    output wb_entry_t     entries [DEPTH],
    output logic [PW-1:0] head_ptr
`endif
);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [CW-1:0] count_next;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two; full is kept as a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
        end
    end

`ifdef ALU_WB_BYPASS_EN
    assign entries  = mem;
    assign head_ptr = rd_ptr;
`endif

endmodule

// File: rtl/alu_wb_stage.sv
// Write-back stage after the 4-bit ALU: pending-write FIFO, register file, Z/C/S flags.
// Define ALU_WB_BYPASS_EN to let reads see pending FIFO writes.
module alu_wb_stage
    import alu_wb_pkg::*;
#(
    parameter  int unsigned WIDTH = DEF_WIDTH,
    parameter  int unsigned NREGS = DEF_NREGS,
    parameter  int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned AW    = $clog2(NREGS),
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    alu_wb_stage_if.slave    alu,
    input  logic             drain_en,
    input  logic [AW-1:0]    rd_a_addr,
    input  logic [AW-1:0]    rd_b_addr,
    output logic [WIDTH-1:0] rd_a,
    output logic [WIDTH-1:0] rd_b,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_s,
    output logic [CW-1:0]    count
);

    // The entry struct is sized by the package defaults.
    if (WIDTH != DEF_WIDTH || NREGS != DEF_NREGS ||
        DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("alu_wb_stage: unsupported WIDTH/NREGS/DEPTH");
    end

    wb_entry_t        push_data;
    wb_entry_t        head;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] regs [NREGS];
    logic [2:0]       flags;
`ifdef ALU_WB_BYPASS_EN
    wb_entry_t        entries [DEPTH];
    logic [PW-1:0]    head_ptr;
`endif

    assign alu.in_ready = !full;
    assign push         = alu.in_valid && alu.in_ready;
    assign pop          = drain_en && !empty;

    always_comb begin
        push_data         = '0;
        push_data.r       = alu.r_in;
        push_data.z       = alu.zero_in;
        push_data.c       = known_one(alu.carry_in);
        push_data.l       = alu_mode_e'(alu.l_in);
        push_data.s       = (alu_mode_e'(alu.l_in) == MODE_ARITH) && known_one(alu.sign_in);
        push_data.addr    = alu.wr_addr;
        push_data.we      = alu.we;
        push_data.flag_we = alu.flag_we;
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
`ifdef ALU_WB_BYPASS_EN
        ,
        .entries   (entries),
        .head_ptr  (head_ptr)
`endif
    );

    // Logic-mode results carry X on C/S, so only Z is taken from them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            flags <= '0;
        end else if (pop) begin
            if (head.we) begin
                regs[head.addr] <= head.r;
            end
            if (head.flag_we) begin
                flags[FLAG_Z] <= head.z;
                if (head.l == MODE_ARITH) begin
                    flags[FLAG_C] <= head.c;
                    flags[FLAG_S] <= head.s;
                end
            end
        end
    end

    assign flag_z = flags[FLAG_Z];
    assign flag_c = flags[FLAG_C];
    assign flag_s = flags[FLAG_S];

`ifdef ALU_WB_BYPASS_EN
    // Scan oldest to youngest so the youngest matching pending write wins.
    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] a);
        logic [WIDTH-1:0] v;
        logic [PW-1:0]    idx;
        v = regs[a];
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_ptr + PW'(i);
            if (i < 32'(count) && entries[idx].we && entries[idx].addr == a) begin
                v = entries[idx].r;
            end
        end
        return v;
    endfunction

    always_comb begin
        rd_a = read_port(rd_a_addr);
        rd_b = read_port(rd_b_addr);
    end
`else
    assign rd_a = regs[rd_a_addr];
    assign rd_b = regs[rd_b_addr];
`endif

endmodule
